gpio_host_seq: RTL and testbench
================================

Name: gpio_host_seq

Overview:
- Bus initiator that drives the gpioemu slave port (saddress/srd/swr/sdata) from a simple command interface.
- Per command: writes A1 and A2, pulses start, polls status, reads result W (two reads) and ones count, then returns them on a result interface.
- Sits between the test or system controller and the gpioemu instance; replaces hand-written host bus sequences.

Parameters:
- STROBE_CYC, 2, clk cycles srd/swr is held high per access (>=1)
- POLL_GAP, 4, idle cycles between successive status reads
- MAX_POLLS, 255, status reads before giving up (timeout)

Ports:
- clk  in  1  system clock, all logic on rising edge
- n_reset  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high when idle and a command is accepted
- cmd_a1  in  24  first argument
- cmd_a2  in  24  second argument
- saddress  out  16  slave address
- srd  out  1  read strobe (slave acts on rising edge)
- swr  out  1  write strobe (slave acts on rising edge)
- sdata_wr  out  32  write data, to slave sdata_in
- sdata_rd  in  32  read data, from slave sdata_out
- res_valid  out  1  one-cycle pulse: results valid
- res_w  out  32  result word
- res_ones  out  24  ones count (sdata_rd[23:0] of the count read)
- res_timeout  out  1  valid with res_valid; 1 = poll limit hit

Behaviour:
- Reset (n_reset=0 at a clk edge):
  - Outputs: saddress=0, srd=0, swr=0, sdata_wr=0, res_valid=0, res_w=0, res_ones=0, res_timeout=0, cmd_ready=1.
  - State returns to IDLE.
  - Reset mid-access drops the strobe on the same edge; no completion pulse is issued.
- Command handshake:
  - Accepted when cmd_valid & cmd_ready; a1/a2 are captured and cmd_ready=0 next cycle.
  - cmd_valid while busy is ignored and not queued.
- Access timing (per access):
  - SETUP: 1 cycle; saddress/sdata_wr driven, strobes low.
  - STROBE: STROBE_CYC cycles; srd or swr high.
  - HOLD: 1 cycle; strobe low, address/data held.
  - A read samples sdata_rd in HOLD, because the slave registers data on the strobe rising edge.
  - An access is therefore STROBE_CYC+2 cycles; srd and swr are never high together.
- Address constants: A1=0x037F, A2=0x0388, CTRL/STATUS=0x03A0, RESULT=0x0390, COUNT=0x0398.
- FSM sequence:
  - IDLE
  - WR_A1: data {8'h0, a1}
  - WR_A2: data {8'h0, a2}
  - WR_GO: addr 0x03A0, data 0
  - POLL: read 0x03A0
    - status[1:0]==2'b11 means busy → GAP.
    - Any other value means done → RD_W0.
  - GAP: wait POLL_GAP cycles → POLL.
  - Poll counter (8 bits, saturating compare): after MAX_POLLS busy reads → RD_W0 with timeout flag set.
  - RD_W0: read 0x0390; data discarded (slave returns the previously latched W).
  - RD_W1: read 0x0390 → res_w.
  - RD_CNT: read 0x0398 → res_ones.
  - DONE: res_valid=1 for 1 cycle → IDLE with cmd_ready=1 on the following cycle.
- Total latency with no busy polls and STROBE_CYC=2: 7 accesses × 4 = 28 cycles + 1 DONE.
- Result registers hold their values until the next DONE; res_timeout clears on accept.
- A poll count reaching exactly MAX_POLLS counts as timeout; MAX_POLLS=0 means a single poll, then read.

Decomposition:
- Package gpio_host_pkg:
  - address localparams (ADDR_A1, ADDR_A2, ADDR_CTRL, ADDR_RESULT, ADDR_COUNT)
  - STATUS_BUSY=2'b11
  - FSM state enum (4-bit)
- Sub-module gpio_bus_cycle:
  - One access engine: start, is_read, addr, wdata in; busy, done, rdata out; SETUP/STROBE/HOLD timing.
  - The top FSM only sequences accesses.

Test Plan:
- Reset mid-WR_A2 (strobe high), n_reset=0 one cycle → next cycle all outputs 0, cmd_ready=1; the next command runs the full sequence from WR_A1.
- cmd_a1=0x000003, cmd_a2=0x000004; model returns status 2'b00 on the first poll, W=0x00000030, count=0x000001 → swr pulses at 0x37F(3), 0x388(4), 0x3A0(0); srd at 0x3A0, 0x390 ×2, 0x398; res_valid with res_w=0x30, res_ones=1, res_timeout=0, 29 cycles after accept.
- Model status 2'b11 for 3 polls then 2'b01 → exactly 4 reads of 0x3A0, each separated by POLL_GAP=4 idle cycles; results as above.
- Status stuck at 2'b11, MAX_POLLS=5 → 5 polls, then result reads; res_timeout=1 with res_valid.
- cmd_valid held high during an operation with different args → ignored; exactly one res_valid per accepted command; the second command starts only after cmd_ready is seen.

Source files
------------

// File: rtl/gpio_host_pkg.sv
// gpio_host_pkg: gpioemu register addresses, busy status code and state encodings shared by the host sequencer
package gpio_host_pkg;
  localparam logic [15:0] ADDR_A1     = 16'h037F;
  localparam logic [15:0] ADDR_A2     = 16'h0388;
  localparam logic [15:0] ADDR_CTRL   = 16'h03A0;
  localparam logic [15:0] ADDR_RESULT = 16'h0390;
  localparam logic [15:0] ADDR_COUNT  = 16'h0398;
  localparam logic [1:0]  STATUS_BUSY = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_A1, S_WR_A2, S_WR_GO, S_POLL, S_GAP, S_RD_W0, S_RD_W1, S_RD_CNT, S_DONE
  } host_state_t;
  typedef enum logic [1:0] {B_IDLE, B_SETUP, B_STROBE, B_HOLD} bus_state_t;
endpackage

// File: rtl/gpio_bus_cycle.sv
// gpio_bus_cycle: one SETUP/STROBE/HOLD slave access; in: clk, n_reset, start, is_read, addr, wdata, sdata_rd; out: busy, done (HOLD cycle), rdata, saddress, srd, swr, sdata_wr
module gpio_bus_cycle
  import gpio_host_pkg::*;
#(
  parameter int STROBE_CYC = 2
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        start,
  input  logic        is_read,
  input  logic [15:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd
);
  bus_state_t st, st_d;
  logic [7:0] cnt;
  logic rd_q, go;
  always_comb begin
    go = start & (st == B_IDLE | st == B_HOLD);
    st_d = go ? B_SETUP :
           st == B_SETUP ? B_STROBE :
           st == B_STROBE ? (cnt == 8'(STROBE_CYC - 1) ? B_HOLD : B_STROBE) : B_IDLE;
  end
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      st       <= B_IDLE;
      cnt      <= '0;
      rd_q     <= 1'b0;
      saddress <= '0;
      sdata_wr <= '0;
    end else begin
      st  <= st_d;
      cnt <= st == B_STROBE ? cnt + 8'd1 : 8'd0;
      if (go) begin
        rd_q     <= is_read;
        saddress <= addr;
        sdata_wr <= wdata;
      end
    end
  end
  assign srd   = st == B_STROBE & rd_q;
  assign swr   = st == B_STROBE & ~rd_q;
  assign busy  = st != B_IDLE;
  assign done  = st == B_HOLD;
  assign rdata = sdata_rd;
endmodule

// File: rtl/gpio_host_seq.sv
// gpio_host_seq: runs write A1/A2, go, status poll, result/count reads on gpioemu per command; in: clk, n_reset, cmd_valid/a1/a2, sdata_rd; out: cmd_ready, saddress/srd/swr/sdata_wr, res_valid/w/ones/timeout
module gpio_host_seq
  import gpio_host_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int POLL_GAP   = 4,
  parameter int MAX_POLLS  = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_wr,
  input  logic [31:0] sdata_rd,
  output logic        res_valid,
  output logic [31:0] res_w,
  output logic [23:0] res_ones,
  output logic        res_timeout
);
  host_state_t state, state_d;
  logic start, is_read, eng_busy, done;
  logic [15:0] addr;
  logic [31:0] wdata, rdata, w_q;
  logic [23:0] a2_q;
  logic [7:0] poll_cnt, gap_cnt;
  logic st_busy, tmo_hit, poll_again, gap_last;
  gpio_bus_cycle #(.STROBE_CYC(STROBE_CYC)) u_bus (
    .clk      (clk),
    .n_reset  (n_reset),
    .start    (start),
    .is_read  (is_read),
    .addr     (addr),
    .wdata    (wdata),
    .busy     (eng_busy),
    .done     (done),
    .rdata    (rdata),
    .saddress (saddress),
    .srd      (srd),
    .swr      (swr),
    .sdata_wr (sdata_wr),
    .sdata_rd (sdata_rd)
  );
  assign cmd_ready  = state == S_IDLE & ~eng_busy;
  assign res_valid  = state == S_DONE;
  assign st_busy    = rdata[1:0] == STATUS_BUSY;
  assign tmo_hit    = {1'b0, poll_cnt} + 9'd1 >= 9'(MAX_POLLS);
  assign poll_again = st_busy & ~tmo_hit;
  assign gap_last   = gap_cnt == 8'(POLL_GAP - 1);
  // Each access is launched on the HOLD cycle of the previous one so accesses run back to back.
  always_comb begin
    state_d = state;
    start   = 1'b0;
    is_read = 1'b0;
    addr    = '0;
    wdata   = '0;
    case (state)
      S_IDLE: if (cmd_valid && cmd_ready) begin
        state_d = S_WR_A1;
        start   = 1'b1;
        addr    = ADDR_A1;
        wdata   = {8'h0, cmd_a1};
      end
      S_WR_A1: if (done) begin
        state_d = S_WR_A2;
        start   = 1'b1;
        addr    = ADDR_A2;
        wdata   = {8'h0, a2_q};
      end
      S_WR_A2: if (done) begin
        state_d = S_WR_GO;
        start   = 1'b1;
        addr    = ADDR_CTRL;
      end
      S_WR_GO: if (done) begin
        state_d = S_POLL;
        start   = 1'b1;
        is_read = 1'b1;
        addr    = ADDR_CTRL;
      end
      S_POLL: if (done) begin
        state_d = poll_again ? (POLL_GAP == 0 ? S_POLL : S_GAP) : S_RD_W0;
        start   = ~poll_again | (POLL_GAP == 0);
        is_read = 1'b1;
        addr    = poll_again ? ADDR_CTRL : ADDR_RESULT;
      end
      S_GAP: if (gap_last) begin
        state_d = S_POLL;
        start   = 1'b1;
        is_read = 1'b1;
        addr    = ADDR_CTRL;
      end
      S_RD_W0: if (done) begin
        state_d = S_RD_W1;
        start   = 1'b1;
        is_read = 1'b1;
        addr    = ADDR_RESULT;
      end
      S_RD_W1: if (done) begin
        state_d = S_RD_CNT;
        start   = 1'b1;
        is_read = 1'b1;
        addr    = ADDR_COUNT;
      end
      S_RD_CNT: if (done) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  // W is staged so the visible result registers only change when the command completes.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state       <= S_IDLE;
      a2_q        <= '0;
      poll_cnt    <= '0;
      gap_cnt     <= '0;
      w_q         <= '0;
      res_w       <= '0;
      res_ones    <= '0;
      res_timeout <= 1'b0;
    end else begin
      state   <= state_d;
      gap_cnt <= state == S_GAP ? gap_cnt + 8'd1 : 8'd0;
      if (state == S_IDLE && cmd_valid && cmd_ready) begin
        a2_q        <= cmd_a2;
        poll_cnt    <= '0;
        res_timeout <= 1'b0;
      end
      if (state == S_POLL && done && st_busy) begin
        poll_cnt <= poll_cnt + 8'd1;
        if (tmo_hit) res_timeout <= 1'b1;
      end
      if (state == S_RD_W1 && done) w_q <= rdata;
      if (state == S_RD_CNT && done) begin
        res_w    <= w_q;
        res_ones <= rdata[23:0];
      end
    end
  end
endmodule

// File: tb/tb_gpio_host_seq.sv
// tb_gpio_host_seq: gpioemu slave model, table-driven and random commands, reset and hold-valid corner cases
module tb_gpio_host_seq;
  localparam int SC = 2, PG = 4, MP = 5, ACC = SC + 2;
  localparam logic [15:0] A_A1 = 16'h037F, A_A2 = 16'h0388, A_CTRL = 16'h03A0;
  localparam logic [15:0] A_RES = 16'h0390, A_CNT = 16'h0398;
  logic clk = 1'b0, n_reset = 1'b0, cmd_valid = 1'b0;
  logic [23:0] cmd_a1 = '0, cmd_a2 = '0;
  logic cmd_ready, srd, swr, res_valid, res_timeout;
  logic [15:0] saddress;
  logic [31:0] sdata_wr, res_w;
  logic [31:0] sdata_rd = '0;
  logic [23:0] res_ones;
  gpio_host_seq #(.STROBE_CYC(SC), .POLL_GAP(PG), .MAX_POLLS(MP)) dut (
    .clk(clk), .n_reset(n_reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a1(cmd_a1), .cmd_a2(cmd_a2), .saddress(saddress), .srd(srd), .swr(swr),
    .sdata_wr(sdata_wr), .sdata_rd(sdata_rd), .res_valid(res_valid), .res_w(res_w),
    .res_ones(res_ones), .res_timeout(res_timeout)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_bad = 0, n_done = 0, base = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  // slave model: configured per command by the stimulus process, state kept privately here
  int busy_cfg = 0;
  logic [31:0] w_cfg = '0;
  logic [23:0] cnt_cfg = '0;
  int polls = 0, log_n = 0, cyc = 0;
  logic [31:0] latched_w = 32'hDEADBEEF;
  logic [16:0] acc_log [0:4095];
  logic [31:0] dat_log [0:4095];
  int cyc_log [0:4095];
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge swr) begin
    acc_log[log_n] = {1'b0, saddress};
    dat_log[log_n] = sdata_wr;
    cyc_log[log_n] = cyc;
    log_n++;
    if (saddress == A_CTRL) polls = 0;
  end
  always @(posedge srd) begin : rd_resp
    logic [31:0] v;
    v = $urandom;
    if (saddress == A_CTRL) begin
      v[1:0] = polls < busy_cfg ? 2'b11 : 2'($urandom_range(0, 2));
      polls++;
    end else if (saddress == A_RES) begin
      v = latched_w;
      latched_w = w_cfg;
    end else if (saddress == A_CNT) v[23:0] = cnt_cfg;
    sdata_rd <= v;
    acc_log[log_n] = {1'b1, saddress};
    dat_log[log_n] = v;
    cyc_log[log_n] = cyc;
    log_n++;
  end
  int wid_log [0:4095];
  int wn = 0, run = 0, overlap = 0, nvalid = 0;
  always @(negedge clk) begin
    if (srd && swr) overlap++;
    if (res_valid) nvalid++;
    if (srd || swr) run++;
    else if (run > 0) begin
      wid_log[wn] = run;
      wn++;
      run = 0;
    end
  end
  function automatic void model(input int busy, output int p, output bit to, output int c);
    p  = busy < MP ? busy + 1 : MP;
    to = busy >= MP;
    c  = (6 + p) * ACC + (p - 1) * PG + 1;
  endfunction
  task automatic cfg(input int b, input logic [31:0] w, input logic [23:0] c);
    busy_cfg = b;
    w_cfg = w;
    cnt_cfg = c;
  endtask
  task automatic rst_checks(input string tag);
    chk({tag, "_saddress"}, 32'(saddress), 0);
    chk({tag, "_srd"}, 32'(srd), 0);
    chk({tag, "_swr"}, 32'(swr), 0);
    chk({tag, "_sdata_wr"}, sdata_wr, 0);
    chk({tag, "_res_valid"}, 32'(res_valid), 0);
    chk({tag, "_res_w"}, res_w, 0);
    chk({tag, "_res_ones"}, 32'(res_ones), 0);
    chk({tag, "_res_timeout"}, 32'(res_timeout), 0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
  endtask
  task automatic issue(input logic [23:0] a1, input logic [23:0] a2, input bit hold);
    int t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_issue", 32'(cmd_ready), 1);
    base = log_n;
    cmd_a1 = a1;
    cmd_a2 = a2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) cmd_valid = 1'b0;
    chk("ready_low_after_accept", 32'(cmd_ready), 0);
    chk("timeout_clear_on_accept", 32'(res_timeout), 0);
  endtask
  task automatic finish_cmd(input logic [23:0] a1, input logic [23:0] a2, input logic [31:0] w,
                            input logic [23:0] c, input int p, input bit to, input int expc);
    int n = 0;
    logic [16:0] ea[$];
    logic [31:0] ed[$];
    while (!res_valid && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n + 1, expc);
    chk("res_w", res_w, w);
    chk("res_ones", 32'(res_ones), 32'(c));
    chk("res_timeout", 32'(res_timeout), 32'(to));
    @(posedge clk);
    #1;
    chk("res_valid_one_cycle", 32'(res_valid), 0);
    chk("res_w_held", res_w, w);
    n_done++;
    ea.push_back({1'b0, A_A1});  ed.push_back({8'h0, a1});
    ea.push_back({1'b0, A_A2});  ed.push_back({8'h0, a2});
    ea.push_back({1'b0, A_CTRL}); ed.push_back(32'h0);
    for (int i = 0; i < p; i++) begin
      ea.push_back({1'b1, A_CTRL}); ed.push_back(32'h0);
    end
    ea.push_back({1'b1, A_RES}); ed.push_back(32'h0);
    ea.push_back({1'b1, A_RES}); ed.push_back(32'h0);
    ea.push_back({1'b1, A_CNT}); ed.push_back(32'h0);
    chk("n_access", log_n - base, ea.size());
    for (int i = 0; i < ea.size() && base + i < log_n; i++) begin
      chk($sformatf("acc%0d_addr", i), 32'(acc_log[base + i]), 32'(ea[i]));
      if (!ea[i][16]) chk($sformatf("acc%0d_wdata", i), dat_log[base + i], ed[i]);
      chk($sformatf("acc%0d_strobe_width", i), wid_log[base + i], SC);
      if (i > 0)
        chk($sformatf("acc%0d_spacing", i), cyc_log[base + i] - cyc_log[base + i - 1],
            (ea[i] == {1'b1, A_CTRL} && ea[i - 1] == {1'b1, A_CTRL}) ? ACC + PG : ACC);
    end
  endtask
  typedef struct {
    logic [23:0] a1, a2;
    int busy;
    logic [31:0] w;
    logic [23:0] cnt;
    int polls;
    bit to;
    int cyc;
  } vec_t;
  vec_t tbl [6];
  initial begin
    int p, c, b, nv0, t;
    bit to;
    logic [23:0] a1, a2, cn;
    logic [31:0] w;
    tbl[0] = '{24'h000003, 24'h000004, 0,    32'h00000030, 24'h000001, 1, 1'b0, 29};
    tbl[1] = '{24'h000003, 24'h000004, 3,    32'h00000030, 24'h000001, 4, 1'b0, 53};
    tbl[2] = '{24'hABCDEF, 24'h123456, 4,    32'hCAFEF00D, 24'hFFFFFF, 5, 1'b0, 61};
    tbl[3] = '{24'h000001, 24'hFFFFFF, 5,    32'h12345678, 24'h000010, 5, 1'b1, 61};
    tbl[4] = '{24'h5A5A5A, 24'hA5A5A5, 1,    32'h0F0F0F0F, 24'h000000, 2, 1'b0, 37};
    tbl[5] = '{24'h800000, 24'h000001, 1000, 32'h80000001, 24'h7FFFFF, 5, 1'b1, 61};
    repeat (3) @(posedge clk);
    #1;
    rst_checks("reset");
    @(negedge clk) n_reset = 1'b1;
    foreach (tbl[i]) begin
      cfg(tbl[i].busy, tbl[i].w, tbl[i].cnt);
      issue(tbl[i].a1, tbl[i].a2, 1'b0);
      finish_cmd(tbl[i].a1, tbl[i].a2, tbl[i].w, tbl[i].cnt, tbl[i].polls, tbl[i].to, tbl[i].cyc);
    end
    // cmd_valid stays high with new args during an operation: only taken once idle again
    cfg(0, 32'h11112222, 24'h000ABC);
    issue(24'h111111, 24'h222222, 1'b1);
    cmd_a1 = 24'h333333;
    cmd_a2 = 24'h444444;
    finish_cmd(24'h111111, 24'h222222, 32'h11112222, 24'h000ABC, 1, 1'b0, 29);
    chk("ready_back_in_idle", 32'(cmd_ready), 1);
    cfg(2, 32'h33334444, 24'h000DEF);
    base = log_n;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("hold_second_accepted", 32'(cmd_ready), 0);
    model(2, p, to, c);
    finish_cmd(24'h333333, 24'h444444, 32'h33334444, 24'h000DEF, p, to, c);
    // reset while the A2 write strobe is high
    cfg(5, 32'h99999999, 24'h000099);
    issue(24'h0000AA, 24'h0000BB, 1'b0);
    t = 0;
    @(negedge clk);
    while (!(swr && saddress == A_A2) && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("reached_wr_a2_strobe", 32'(swr && saddress == A_A2), 1);
    nv0 = nvalid;
    n_reset = 1'b0;
    @(posedge clk);
    #1;
    rst_checks("midreset");
    @(negedge clk) n_reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_result_after_abort", nvalid, nv0);
    cfg(0, 32'h00000030, 24'h000001);
    issue(24'h000003, 24'h000004, 1'b0);
    finish_cmd(24'h000003, 24'h000004, 32'h00000030, 24'h000001, 1, 1'b0, 29);
    for (int k = 0; k < 20; k++) begin
      a1 = 24'($urandom);
      a2 = 24'($urandom);
      w  = $urandom;
      cn = 24'($urandom);
      b  = $urandom_range(0, 7) == 0 ? 1000 : int'($urandom_range(0, 6));
      model(b, p, to, c);
      cfg(b, w, cn);
      issue(a1, a2, 1'b0);
      finish_cmd(a1, a2, w, cn, p, to, c);
    end
    repeat (3) @(negedge clk);
    chk("res_valid_pulses", nvalid, n_done);
    chk("strobe_overlap", overlap, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
